uart_rx_frame_counter: RTL and testbench

//  Parametrised successor of the UART RX edge/bit counter. Counts oversampling edges per bit and bits per frame.

---
 rtl/uart_rx_pkg.sv | 32 +++
 rtl/uart_rx_strobe_decode.sv | 32 +++
 rtl/uart_rx_frame_counter.sv | 111 +++++++++++
 tb/tb_uart_rx_frame_counter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: counter FSM states,
// legal oversampling ratios and frame-length helper.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      HOLD,
      ERR
   } state_t;

   localparam int PRESC_8  = 8;
   localparam int PRESC_16 = 16;
   localparam int PRESC_32 = 32;

   function automatic int frame_bits(
      input int   data_width,
      input logic parity_en,
      input logic stop2
   );
      return 1 + data_width + (parity_en ? 1 : 0) + (stop2 ? 2 : 1);
   endfunction

   function automatic logic prescale_legal(
      input int p,
      input int max_p
   );
      return ((p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32))
             && (p <= max_p);
   endfunction

endpackage

// File: rtl/uart_rx_strobe_decode.sv
// Combinational mid-bit sample strobes and bit/frame
// completion flags, decoded from the registered counters.
module uart_rx_strobe_decode #(
   parameter int PRESCALE_W = 6,
   parameter int EDGE_W     = 5,
   parameter int BIT_W      = 4
) (
   input  logic                  active,
   input  logic [EDGE_W-1:0]     edge_count,
   input  logic [BIT_W-1:0]      bit_count,
   input  logic [BIT_W-1:0]      last_bit,
   input  logic [PRESCALE_W-1:0] p,
   output logic [2:0]            sample_stb,
   output logic                  bit_done,
   output logic                  frame_done
);

   logic [PRESCALE_W-1:0] ec;
   logic [PRESCALE_W-1:0] half;

   assign ec   = PRESCALE_W'(edge_count);
   assign half = p >> 1;

   // Three strobes straddle the bit centre for the majority vote
   assign sample_stb[0] = active && (ec == half - PRESCALE_W'(2));
   assign sample_stb[1] = active && (ec == half - PRESCALE_W'(1));
   assign sample_stb[2] = active && (ec == half);

   assign bit_done   = active && (ec == p - PRESCALE_W'(1));
   assign frame_done = bit_done && (bit_count == last_bit);

endmodule

// File: rtl/uart_rx_frame_counter.sv
// UART RX edge/bit counter: oversampling edges per bit,
// bits per frame, with prescale/format latched per frame.
module uart_rx_frame_counter
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int MAX_PRESCALE = 32,
   parameter int PRESCALE_W   = 6,
   parameter int EDGE_W       = 5,
   parameter int BIT_W        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  counter_enable,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  parity_en,
   input  logic                  stop2,
   output logic [EDGE_W-1:0]     edge_count,
   output logic [BIT_W-1:0]      bit_count,
   output logic [2:0]            sample_stb,
   output logic                  bit_done,
   output logic                  frame_done,
   output logic                  cfg_err
);

   state_t                state_q;
   state_t                state_d;
   logic [PRESCALE_W-1:0] p_q;
   logic                  par_q;
   logic                  stop2_q;
   logic [EDGE_W-1:0]     edge_q;
   logic [BIT_W-1:0]      bit_q;
   logic                  cfg_err_q;
   logic [BIT_W-1:0]      last_bit;
   logic                  legal;

   assign legal    = prescale_legal(int'(prescale), MAX_PRESCALE);
   assign last_bit = BIT_W'(frame_bits(DATA_WIDTH, par_q, stop2_q) - 1);

   uart_rx_strobe_decode #(
      .PRESCALE_W (PRESCALE_W),
      .EDGE_W     (EDGE_W),
      .BIT_W      (BIT_W)
   ) u_decode (
      .active     (state_q == COUNT),
      .edge_count (edge_q),
      .bit_count  (bit_q),
      .last_bit   (last_bit),
      .p          (p_q),
      .sample_stb (sample_stb),
      .bit_done   (bit_done),
      .frame_done (frame_done)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (counter_enable) state_d = legal ? COUNT : ERR;
         end
         COUNT: begin
            if (!counter_enable)  state_d = IDLE;
            else if (frame_done)  state_d = HOLD;
         end
         HOLD: begin
            if (!counter_enable) state_d = IDLE;
         end
         ERR: begin
            if (!counter_enable) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         p_q       <= PRESCALE_W'(PRESC_8);
         par_q     <= 1'b0;
         stop2_q   <= 1'b0;
         edge_q    <= '0;
         bit_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_err_q <= (state_d == ERR);
         if (state_q == IDLE && counter_enable && legal) begin
            p_q     <= prescale;
            par_q   <= parity_en;
            stop2_q <= stop2;
         end
         // Counters run only inside an enabled, unfinished frame
         if (state_q == COUNT && counter_enable && !frame_done) begin
            if (bit_done) begin
               edge_q <= '0;
               bit_q  <= bit_q + BIT_W'(1);
            end else begin
               edge_q <= edge_q + EDGE_W'(1);
            end
         end else begin
            edge_q <= '0;
            bit_q  <= '0;
         end
      end
   end

   assign edge_count = edge_q;
   assign bit_count  = bit_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Directed bench for uart_rx_frame_counter: frame timing,
// strobe placement, config latching, error and reset paths.
module tb_uart_rx_frame_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       counter_enable;
   logic [5:0] prescale;
   logic       parity_en;
   logic       stop2;
   logic [4:0] edge_count;
   logic [3:0] bit_count;
   logic [2:0] sample_stb;
   logic       bit_done;
   logic       frame_done;
   logic       cfg_err;

   int vectors = 0;
   int miscompares = 0;

   uart_rx_frame_counter dut (
      .clk            (clk),
      .rst            (rst),
      .counter_enable (counter_enable),
      .prescale       (prescale),
      .parity_en      (parity_en),
      .stop2          (stop2),
      .edge_count     (edge_count),
      .bit_count      (bit_count),
      .sample_stb     (sample_stb),
      .bit_done       (bit_done),
      .frame_done     (frame_done),
      .cfg_err        (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_edge"}, int'(edge_count), 0);
      chk({tag, "_bit"}, int'(bit_count), 0);
      chk({tag, "_stb"}, int'(sample_stb), 0);
      chk({tag, "_bdone"}, int'(bit_done), 0);
      chk({tag, "_fdone"}, int'(frame_done), 0);
   endtask

   // Walks one frame from cycle 'start', checking every output
   // against the ideal edge/bit position for ratio p.
   task automatic run_frame(input int p, input int fb, input int start);
      int e, b, stb_exp;
      for (int n = start; n < p * fb; n++) begin
         e = n % p;
         b = n / p;
         stb_exp = (e == p/2 - 2) ? 1 :
                   (e == p/2 - 1) ? 2 :
                   (e == p/2)     ? 4 : 0;
         chk("edge", int'(edge_count), e);
         chk("bit", int'(bit_count), b);
         chk("stb", int'(sample_stb), stb_exp);
         chk("bit_done", int'(bit_done), (e == p - 1) ? 1 : 0);
         chk("frame_done", int'(frame_done),
             (e == p - 1 && b == fb - 1) ? 1 : 0);
         tick();
      end
   endtask

   initial begin
      rst = 1'b0;
      counter_enable = 1'b0;
      prescale = 6'd8;
      parity_en = 1'b0;
      stop2 = 1'b0;
      #1;
      chk_quiet("reset");
      chk("reset_cfg_err", int'(cfg_err), 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_quiet("idle");

      // 1: P=8, 8N1 -> 10 bits, frame_done on COUNT cycle 80
      counter_enable = 1'b1;
      tick();
      run_frame(8, 10, 0);
      for (int i = 0; i < 3; i++) chk_quiet("hold1");

      // 2: P=16, parity, two stops -> 12 bits, 192 cycles
      counter_enable = 1'b0;
      tick();
      prescale = 6'd16;
      parity_en = 1'b1;
      stop2 = 1'b1;
      counter_enable = 1'b1;
      tick();
      run_frame(16, 12, 0);
      for (int i = 0; i < 5; i++) begin
         chk_quiet("hold2");
         tick();
      end

      // 3: illegal prescale -> ERR
      counter_enable = 1'b0;
      tick();
      prescale = 6'd12;
      parity_en = 1'b0;
      stop2 = 1'b0;
      counter_enable = 1'b1;
      tick();
      chk("err_set", int'(cfg_err), 1);
      chk_quiet("err1");
      tick();
      chk("err_hold", int'(cfg_err), 1);
      chk_quiet("err2");
      counter_enable = 1'b0;
      tick();
      chk("err_clear", int'(cfg_err), 0);

      // 4: abort at bit 3 edge 5, then full restart
      prescale = 6'd8;
      counter_enable = 1'b1;
      tick();
      run_frame(8, 10, 0 + 0 * 29);
      counter_enable = 1'b0;
      tick();
      counter_enable = 1'b1;
      tick();
      for (int i = 0; i < 29; i++) tick();
      chk("abort_edge_pre", int'(edge_count), 5);
      chk("abort_bit_pre", int'(bit_count), 3);
      counter_enable = 1'b0;
      tick();
      chk_quiet("abort");
      counter_enable = 1'b1;
      tick();
      run_frame(8, 10, 0);

      // 5: prescale change mid-frame ignored until next frame
      counter_enable = 1'b0;
      tick();
      counter_enable = 1'b1;
      tick();
      run_frame(8, 10, 0 + 0);
      counter_enable = 1'b0;
      tick();
      counter_enable = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) tick();
      prescale = 6'd32;
      run_frame(8, 10, 10);
      counter_enable = 1'b0;
      tick();
      counter_enable = 1'b1;
      tick();
      run_frame(32, 10, 0);

      // 6: async reset between clock edges
      counter_enable = 1'b0;
      tick();
      prescale = 6'd8;
      counter_enable = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) tick();
      chk("pre_rst_edge", int'(edge_count), 5);
      #2 rst = 1'b0;
      #1;
      chk_quiet("async_rst");
      chk("async_rst_cfg_err", int'(cfg_err), 0);
      counter_enable = 1'b0;
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_quiet("post_rst");
      end
      counter_enable = 1'b1;
      tick();
      chk("resume_edge0", int'(edge_count), 0);
      chk("resume_bit0", int'(bit_count), 0);
      tick();
      chk("resume_edge1", int'(edge_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
